// File: rtl/iob_moddncnt_pkg.sv
// iob_moddncnt_pkg: FSM state encoding and parameter defaults for the modulo down-counter.
package iob_moddncnt_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int RST_VAL_DEF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iob_moddncnt_reg.sv
// iob_reg_care: register with clock enable and synchronous active-high reset.
// Reset only takes effect on an enabled edge; callers fold reset into cke_i when it must always win.
module iob_reg_care #(
    parameter int DATA_W  = 8,
    parameter int RST_VAL = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (cke_i) data_q <= rst_i ? DATA_W'(RST_VAL) : data_i;
    end

    assign data_o = data_q;

endmodule

// File: rtl/iob_moddncnt.sv
// iob_moddncnt: modulo down-counter with IDLE/RUN/DONE control and a terminal-count tick.
// One-shot mode exists only when IOB_MODDNCNT_ONESHOT_EN is defined; otherwise periodic-only.
module iob_moddncnt
    import iob_moddncnt_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RST_VAL = RST_VAL_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] mod_i,
    output logic [DATA_W-1:0] data_o,
    output logic              tick_o,
    output logic              busy_o,
    output logic              done_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_d;
    logic              oneshot;
    logic              tc;

`ifdef IOB_MODDNCNT_ONESHOT_EN
    assign oneshot = mode_i;
    assign done_o  = (state_q == DONE);
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign oneshot     = 1'b0;
    assign done_o      = 1'b0;
`endif

    assign busy_o = (state_q == RUN);

    always_comb begin
        tc      = (state_q == RUN) && (data_o == '0) && en_i;
        tick_o  = tc && cke_i && !rst_i;
        state_d = state_q;
        data_d  = data_o;
        if (stop_i) begin
            state_d = IDLE;
            data_d  = '0;
        end else if (start_i) begin
            state_d = RUN;
            data_d  = mod_i;
        end else if (tc) begin
            state_d = oneshot ? DONE : RUN;
            data_d  = oneshot ? '0 : mod_i;
        end else if (state_q == RUN && en_i) begin
            data_d  = data_o - DATA_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else if (cke_i) state_q <= state_d;
    end

    // Reset must act even while cke_i is low, so it is folded into the enable.
    iob_reg_care #(
        .DATA_W (DATA_W),
        .RST_VAL(RST_VAL)
    ) u_data (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cke_i (cke_i | rst_i),
        .data_i(data_d),
        .data_o(data_o)
    );

endmodule

// File: tb/tb_iob_moddncnt.sv
// tb_iob_moddncnt: directed and randomized checks of iob_moddncnt against a behavioural model.
module tb_iob_moddncnt;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0, cke = 1'b0, en = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [W-1:0] mod_v = '0;
    logic [W-1:0] data;
    logic         tick, busy, done;

    int checks = 0;
    int passed = 0;

    int m_state = 0;
    int m_cnt   = 0;
`ifdef IOB_MODDNCNT_ONESHOT_EN
    localparam bit HAS_ONESHOT = 1'b1;
`else
    localparam bit HAS_ONESHOT = 1'b0;
`endif

    iob_moddncnt #(.DATA_W(W), .RST_VAL(0)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .cke_i  (cke),
        .en_i   (en),
        .start_i(start),
        .stop_i (stop),
        .mode_i (mode),
        .mod_i  (mod_v),
        .data_o (data),
        .tick_o (tick),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // One cycle: drive inputs, compare pre-edge outputs with the model, then advance the model.
    task automatic cyc(input bit r, input bit c, input bit e, input bit s, input bit p,
                       input bit m, input int md);
        int exp_tick;
        @(negedge clk);
        rst = r; cke = c; en = e; start = s; stop = p; mode = m; mod_v = W'(md);
        #1;
        exp_tick = (m_state == 1 && m_cnt == 0 && e && c && !r) ? 1 : 0;
        check("data", int'(data), m_cnt);
        check("tick", int'(tick), exp_tick);
        check("busy", int'(busy), m_state == 1 ? 1 : 0);
        check("done", int'(done), m_state == 2 ? 1 : 0);
        if (r) begin
            m_state = 0; m_cnt = 0;
        end else if (c) begin
            if (p) begin
                m_state = 0; m_cnt = 0;
            end else if (s) begin
                m_state = 1; m_cnt = md;
            end else if (m_state == 1 && e) begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else if (m && HAS_ONESHOT) begin
                    m_state = 2; m_cnt = 0;
                end else m_cnt = md;
            end
        end
    endtask

    initial begin
        // reset, with cke low to show reset is independent of it
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 3);
        cyc(0, 1, 1, 0, 0, 0, 3);
        // periodic mod 3
        cyc(0, 1, 1, 1, 0, 0, 3);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, 0, 3);
        // mod change mid-count only lands on reload
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0, 1);
        // gating with mod 5
        cyc(0, 1, 1, 1, 0, 0, 5);
        for (int i = 0; i < 14; i++) cyc(0, 1, i % 2 == 0, 0, 0, 0, 5);
        // one-shot mod 2 and DONE hold
        cyc(0, 1, 1, 1, 0, 1, 2);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 1, 2);
        // start+stop together in RUN
        cyc(0, 1, 1, 1, 0, 0, 4);
        cyc(0, 1, 1, 0, 0, 0, 4);
        cyc(0, 1, 1, 1, 1, 0, 4);
        cyc(0, 1, 1, 0, 0, 0, 4);
        // start exactly at terminal count ticks and reloads
        cyc(0, 1, 1, 1, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 0, 6);
        cyc(0, 1, 1, 0, 0, 0, 6);
        // cke low ignores start/stop and freezes count
        cyc(0, 0, 1, 0, 1, 0, 6);
        cyc(0, 0, 1, 1, 0, 0, 2);
        cyc(0, 1, 1, 0, 0, 0, 6);
        // reset mid-run at 4 with cke low
        cyc(0, 1, 1, 1, 0, 0, 4);
        cyc(1, 0, 1, 0, 0, 0, 4);
        cyc(0, 1, 1, 0, 0, 0, 4);
        // mod 0 periodic ticks constantly
        cyc(0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0, 0);
        // randomized
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/iob_moddncnt.md
IOB_MODDNCNT -- requirements
Module: iob_moddncnt

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the modulus and count.
REQ-002 SHALL have parameter RST_VAL, default 0: count value after reset.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cke_i, input, 1 bit: clock enable; 0 freezes all state.
REQ-006 SHALL have port en_i, input, 1 bit: count enable while running.
REQ-007 SHALL have port start_i, input, 1 bit: load mod_i and begin or restart counting.
REQ-008 SHALL have port stop_i, input, 1 bit: abort to idle.
REQ-009 SHALL have port mode_i, input, 1 bit: 0 selects periodic, 1 selects one-shot.
REQ-010 SHALL have port mod_i, input, DATA_W bits: modulus; the period is mod_i+1 enabled cycles.
REQ-011 SHALL have port data_o, output, DATA_W bits: current down-count value.
REQ-012 SHALL have port tick_o, output, 1 bit: terminal-count pulse.
REQ-013 SHALL have port busy_o, output, 1 bit: high in RUN.
REQ-014 SHALL have port done_o, output, 1 bit: high in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE, start_i=1 SHALL load data_o=mod_i and enter RUN on the next edge.
REQ-017 In RUN with en_i=1 and data_o>0, data_o SHALL decrement by 1 per cycle.
REQ-018 In RUN with en_i=0, data_o SHALL hold and tick_o SHALL stay 0.
REQ-019 tick_o SHALL be combinational: 1 exactly when state=RUN, data_o=0, en_i=1, cke_i=1 and rst_i=0.
REQ-020 On a tick in periodic mode, data_o SHALL reload mod_i, sampled on that same edge, and the FSM SHALL remain in RUN.
REQ-021 On a tick in one-shot mode, the FSM SHALL enter DONE with data_o=0.
REQ-022 mod_i=0 SHALL produce tick_o=1 on every enabled RUN cycle in periodic mode.
REQ-023 Changes to mod_i mid-count SHALL take effect only at the next load or reload.
REQ-024 start_i in RUN or DONE SHALL reload mod_i and enter RUN; tick_o is still asserted if its REQ-019 condition holds that cycle.
REQ-025 stop_i in any state SHALL enter IDLE with data_o=0; stop_i SHALL win over a simultaneous start_i.
REQ-026 DONE SHALL hold until start_i or stop_i is asserted.
REQ-027 With cke_i=0, state and data_o SHALL hold and start_i and stop_i SHALL be ignored.
REQ-028 Decrement SHALL never wrap below 0.

Reset
REQ-029 rst_i=1 at an edge SHALL force state=IDLE, data_o=RST_VAL and busy_o=done_o=0, independent of cke_i.
REQ-030 rst_i SHALL override start_i and stop_i; a reset mid-RUN SHALL abort with no tick.
REQ-031 tick_o SHALL be 0 while rst_i=1.

Configuration
REQ-032 Macro IOB_MODDNCNT_ONESHOT_EN SHALL gate one-shot support.
REQ-033 With the macro defined, mode_i SHALL behave per REQ-020 and REQ-021.
REQ-034 Without the macro, mode_i SHALL be ignored, the FSM SHALL operate periodic-only, DONE SHALL be unreachable and done_o SHALL be tied to 0.

Structure
REQ-035 Package iob_moddncnt_pkg SHALL hold the FSM state encoding (2-bit) and the DATA_W and RST_VAL defaults.
REQ-036 The data_o register SHALL be an instance of iob_reg_care, with its clock enable driven by cke_i|rst_i; the next-count and FSM logic SHALL be local.

Verification
REQ-037 Periodic: mod_i=3, start, en_i=1 -> data_o 3,2,1,0,3,...; tick_o every 4th cycle, on data_o=0.
REQ-038 One-shot (macro on): mod_i=2, mode_i=1, start -> data_o 2,1,0; one tick; then DONE, done_o=1, busy_o=0, data_o=0 held.
REQ-039 Gating: en_i toggling 1,0,1 with mod_i=5 -> count holds on en_i=0 cycles; period stretches by the number of disabled cycles.
REQ-040 Simultaneous: start_i=stop_i=1 in RUN -> IDLE, data_o=0; start_i alone at data_o=0 with en_i=1 -> tick_o=1 that cycle and reload.
REQ-041 Reset mid-RUN at data_o=4, RST_VAL=0, cke_i=0 -> next edge IDLE, data_o=0, no tick; mod_i=0 periodic -> tick_o constantly 1 while en_i=1.
